// File: rtl/v_ram_responder.sv
// Vector RAM responder: serialises one 256-bit read or masked write into 32-bit beats
// against an internal word array, then returns the line with a one-cycle done pulse.
module v_ram_responder #(
  parameter int                 VRAM_DW   = 256,
  parameter int                 VRAM_AW   = 32,
  parameter int                 WORD_DW   = 32,
  parameter int                 DEPTH     = 1024,
  parameter logic [VRAM_AW-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vram_ren_i,
  input  logic               vram_wen_i,
  input  logic [VRAM_AW-1:0] vram_addr_i,
  input  logic [VRAM_DW-1:0] vram_mask_i,
  input  logic [VRAM_DW-1:0] vram_din_i,
  output logic [VRAM_DW-1:0] vram_dout_o,
  output logic               vram_busy_o,
  output logic               vram_done_o
);

  localparam int BEATS = VRAM_DW / WORD_DW;
  localparam int IW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    RESP
  } state_e;

  state_e               state_q;
  logic [BW-1:0]        beat_q;
  logic [IW-1:0]        idx_q;
  logic                 rd_q;
  logic                 wr_q;
  logic [VRAM_DW-1:0]   mask_q;
  logic [VRAM_DW-1:0]   din_q;
  logic [VRAM_DW-1:0]   shadow_q;
  logic [VRAM_DW-1:0]   dout_q;
  logic                 done_q;

  logic [WORD_DW-1:0]   mem [DEPTH];
  logic [WORD_DW-1:0]   rdata;
  logic [WORD_DW-1:0]   wdata_d;
  logic [VRAM_DW-1:0]   shadow_d;
  logic [VRAM_AW-1:0]   addr_off;
  logic [IW-1:0]        base_idx;
  logic                 mem_we;

  // Offset from the base is taken modulo the array, so lines and low addresses wrap silently.
  assign addr_off = vram_addr_i - BASE_ADDR;
  assign base_idx = IW'(addr_off >> 2);

  // Mask and data are shifted down one word per beat, so the current slice is always the low word.
  assign rdata    = mem[idx_q];
  assign wdata_d  = (rdata & ~mask_q[WORD_DW-1:0]) | (din_q[WORD_DW-1:0] & mask_q[WORD_DW-1:0]);
  assign shadow_d = {rdata, shadow_q[VRAM_DW-1:WORD_DW]};
  assign mem_we   = rst && (state_q == BEAT) && wr_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (vram_ren_i || vram_wen_i) begin
            state_q <= BEAT;
            beat_q  <= '0;
            idx_q   <= base_idx;
            rd_q    <= vram_ren_i;
            wr_q    <= vram_wen_i;
            mask_q  <= vram_mask_i;
            din_q   <= vram_din_i;
          end else begin
            state_q <= IDLE;
          end
        end
        BEAT: begin
          shadow_q <= shadow_d;
          mask_q   <= mask_q >> WORD_DW;
          din_q    <= din_q >> WORD_DW;
          idx_q    <= idx_q + 1'b1;
          beat_q   <= beat_q + 1'b1;
          if (beat_q == BW'(BEATS - 1)) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            if (rd_q) begin
              dout_q <= shadow_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vram_dout_o = dout_q;
  assign vram_busy_o = (state_q == BEAT);
  assign vram_done_o = done_q;

endmodule

// File: tb/tb_v_ram_responder.sv
// Bench for v_ram_responder: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-level model of the vector RAM.
module tb_v_ram_responder;

  localparam int          DEPTH = 1024;
  localparam int          BEATS = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic         ren;
  logic         wen;
  logic [31:0]  addr;
  logic [255:0] mask;
  logic [255:0] din;
  logic [255:0] dout;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 0;

  v_ram_responder dut (
    .clk         (clk),
    .rst         (rst),
    .vram_ren_i  (ren),
    .vram_wen_i  (wen),
    .vram_addr_i (addr),
    .vram_mask_i (mask),
    .vram_din_i  (din),
    .vram_dout_o (dout),
    .vram_busy_o (busy),
    .vram_done_o (done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Transaction-level model: a request occupies edges start+1..start+8, beat i on edge start+1+i.
  logic [31:0]  modelMem [DEPTH];
  logic [255:0] expDout = '0;
  logic         expDone = 0;
  logic         expBusy = 0;
  bit           mActive = 0;
  bit           mRd, mWr, wasActive;
  int           edgeN = 0;
  int           mStart, mBeat;
  int unsigned  mBase, mIdx;
  logic [255:0] mMask, mDin, mShadow;
  logic [31:0]  mSlice;

  always @(posedge clk) begin
    edgeN++;
    if (!rst) begin
      mActive = 0;
      expDout = '0;
      expDone = 0;
      expBusy = 0;
    end else begin
      wasActive = mActive;
      expDone   = 0;
      if (mActive) begin
        mBeat = edgeN - mStart - 1;
        mIdx  = (mBase + mBeat) % DEPTH;
        mShadow[mBeat*32 +: 32] = modelMem[mIdx];
        if (mWr) begin
          mSlice = mMask[mBeat*32 +: 32];
          modelMem[mIdx] = (modelMem[mIdx] & ~mSlice) | (mDin[mBeat*32 +: 32] & mSlice);
        end
        if (mBeat == BEATS - 1) begin
          expDone = 1;
          if (mRd) expDout = mShadow;
          mActive = 0;
        end
      end
      if (!wasActive && (ren || wen)) begin
        mActive = 1;
        mStart  = edgeN;
        mBase   = ((addr - BASE) >> 2) % DEPTH;
        mRd     = ren;
        mWr     = wen;
        mMask   = mask;
        mDin    = din;
      end
      expBusy = mActive;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model_done", {255'd0, done}, {255'd0, expDone});
      checkOutput("model_busy", {255'd0, busy}, {255'd0, expBusy});
      checkOutput("model_dout", dout, expDout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] a,
                               input logic [255:0] m, input logic [255:0] d);
    ren  = r;
    wen  = w;
    addr = a;
    mask = m;
    din  = d;
    tick();
    ren = 0;
    wen = 0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done === 1'b1) begin
        cycles = k;
        break;
      end
    end
    if (cycles < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no done within 30 cycles expected one");
    end
  endtask

  function automatic logic [255:0] seqLine(input logic [31:0] first, input logic [31:0] step);
    logic [255:0] l;
    for (int k = 0; k < BEATS; k++) l[k*32 +: 32] = first + step * k;
    return l;
  endfunction

  logic [255:0] ones = '1;
  logic [255:0] lineA, lineB, lineC, rnd;
  int           lat, cnt;

  initial begin
    rst = 0; ren = 0; wen = 0; addr = '0; mask = '0; din = '0;
    tick();
    cmpEn = 1;
    tick(); tick();
    checkOutput("reset_dout", dout, '0);
    checkOutput("reset_busy", {255'd0, busy}, '0);
    checkOutput("reset_done", {255'd0, done}, '0);
    rst = 1;
    tick();

    $display("[TB] filling array");
    for (int l = 0; l < DEPTH / BEATS; l++) begin
      for (int k = 0; k < BEATS; k++) rnd[k*32 +: 32] = $urandom;
      applyStimulus(0, 1, BASE + 32'(l * 32), ones, rnd);
      waitDone(lat);
    end

    $display("[TB] full write then read");
    applyStimulus(0, 1, BASE, ones, seqLine(32'h1111_1111, 32'h1111_1111));
    waitDone(lat);
    checkOutput("write_latency", 256'(lat), 256'd8);
    applyStimulus(1, 0, BASE, '0, '0);
    waitDone(lat);
    checkOutput("read_latency", 256'(lat), 256'd8);
    checkOutput("full_read", dout,
      256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

    $display("[TB] partial mask");
    applyStimulus(0, 1, BASE, 256'h0000FFFF << 96, ones);
    waitDone(lat);
    applyStimulus(1, 0, BASE, '0, '0);
    waitDone(lat);
    checkOutput("partial_read", dout,
      256'h88888888_77777777_66666666_55555555_4444FFFF_33333333_22222222_11111111);

    $display("[TB] wrap-around");
    applyStimulus(0, 1, 32'h8000_0FF8, ones, seqLine(32'hA000_0000, 32'd1));
    waitDone(lat);
    applyStimulus(1, 0, BASE, '0, '0);
    waitDone(lat);
    checkOutput("wrap_slices", {64'd0, dout[191:0]},
      {64'd0, 32'hA000_0007, 32'hA000_0006, 32'hA000_0005,
       32'hA000_0004, 32'hA000_0003, 32'hA000_0002});

    $display("[TB] read-before-write");
    lineA = seqLine(32'hAAAA_0000, 32'd1);
    lineB = seqLine(32'hBBBB_0000, 32'd1);
    applyStimulus(0, 1, BASE + 32'h40, ones, lineA);
    waitDone(lat);
    applyStimulus(1, 1, BASE + 32'h40, ones, lineB);
    waitDone(lat);
    checkOutput("rbw_old", dout, lineA);
    applyStimulus(1, 0, BASE + 32'h40, '0, '0);
    waitDone(lat);
    checkOutput("rbw_new", dout, lineB);

    $display("[TB] busy drop and back-to-back");
    lineC = seqLine(32'hC0C0_0000, 32'd3);
    applyStimulus(0, 1, BASE + 32'h80, ones, lineC);
    tick(); tick();
    applyStimulus(0, 1, BASE + 32'h80, ones, '0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
    checkOutput("busy_drop_dones", 256'(cnt), 256'd1);
    applyStimulus(1, 0, BASE + 32'h80, '0, '0);
    waitDone(lat);
    checkOutput("busy_drop_data", dout, lineC);
    applyStimulus(1, 0, BASE + 32'h40, '0, '0);
    waitDone(lat);
    checkOutput("b2b_first", dout, lineB);

    $display("[TB] reset mid-op");
    lineA = seqLine(32'h5A5A_0000, 32'd1);
    lineB = seqLine(32'hB0B0_0000, 32'd1);
    applyStimulus(0, 1, BASE + 32'h200, ones, lineA);
    waitDone(lat);
    applyStimulus(0, 1, BASE + 32'h200, ones, lineB);
    tick(); tick(); tick(); tick();
    rst = 0;
    tick();
    checkOutput("midreset_dout", dout, '0);
    checkOutput("midreset_busy", {255'd0, busy}, '0);
    checkOutput("midreset_done", {255'd0, done}, '0);
    rst = 1;
    tick();
    applyStimulus(1, 0, BASE + 32'h200, '0, '0);
    waitDone(lat);
    checkOutput("midreset_line", dout, {lineA[255:128], lineB[127:0]});

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 2);
      for (int k = 0; k < BEATS; k++) begin
        case ($urandom_range(0, 2))
          0:       mask[k*32 +: 32] = '0;
          1:       mask[k*32 +: 32] = '1;
          default: mask[k*32 +: 32] = $urandom;
        endcase
        rnd[k*32 +: 32] = $urandom;
      end
      applyStimulus(op != 1, op != 0, $urandom, mask, rnd);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        applyStimulus(1, $urandom_range(0, 1) == 1, $urandom, ones, ~rnd);
      end
      waitDone(lat);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
